// File: rtl/mux_gate_scheduler.sv
// Round-robin scheduler that time-shares one external bitwise 2:1 mux between
// requesters, building AND/OR/NOT in one mux pass and XOR in two passes.
module mux_gate_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     op,
    input  logic [WIDTH*NUM_REQ-1:0] a,
    input  logic [WIDTH*NUM_REQ-1:0] b,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [WIDTH-1:0]         res,
    output logic                     busy,
    output logic [WIDTH-1:0]         mux_sel,
    output logic [WIDTH-1:0]         mux_i0,
    output logic [WIDTH-1:0]         mux_i1,
    input  logic [WIDTH-1:0]         mux_out
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOT = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {IDLE, EVAL1, EVAL2, DONE} state_t;

    state_t             r_state, w_next;
    logic [PW-1:0]      r_ptr;
    logic [NUM_REQ-1:0] r_gnt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b, r_temp, r_res;
    logic               w_found;
    logic [PW-1:0]      w_idx, w_nptr;

    // Walk candidates from farthest to nearest so the nearest set bit at or after r_ptr wins.
    always_comb begin : arb
        int j;
        j       = 0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[PW'(j)]) begin
                w_found = 1'b1;
                w_idx   = PW'(j);
            end
        end
    end

    assign w_nptr = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_next = EVAL1;
            EVAL1:   w_next = (r_op == OP_XOR) ? EVAL2 : DONE;
            EVAL2:   w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Mux drive depends only on state and latched operands, never on live inputs.
    always_comb begin
        mux_sel = '0;
        mux_i0  = '0;
        mux_i1  = '0;
        case (r_state)
            EVAL1: begin
                case (r_op)
                    OP_AND: begin mux_sel = r_a; mux_i0 = '0;  mux_i1 = r_b; end
                    OP_OR:  begin mux_sel = r_a; mux_i0 = r_b; mux_i1 = '1;  end
                    OP_NOT: begin mux_sel = r_a; mux_i0 = '1;  mux_i1 = '0;  end
                    default: begin mux_sel = r_b; mux_i0 = '1; mux_i1 = '0;  end
                endcase
            end
            EVAL2: begin mux_sel = r_a; mux_i0 = r_b; mux_i1 = r_temp; end
            default: ;
        endcase
    end

    assign done = (r_state == DONE) ? r_gnt : '0;
    assign busy = (r_state != IDLE);
    assign gnt  = r_gnt;
    assign res  = r_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_gnt  <= '0;
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_temp <= '0;
            r_res  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_gnt <= NUM_REQ'(1) << w_idx;
                    r_op  <= op[2*w_idx +: 2];
                    r_a   <= a[w_idx*WIDTH +: WIDTH];
                    r_b   <= b[w_idx*WIDTH +: WIDTH];
                    r_ptr <= w_nptr;
                end
                EVAL1: if (r_op == OP_XOR) r_temp <= mux_out;
                       else                r_res  <= mux_out;
                EVAL2: r_res <= mux_out;
                default: r_gnt <= '0;
            endcase
        end
    end

endmodule
